// File: rtl/motion_pkg.sv
// motion_pkg: shared types and constants for the motion command sequencer.
package motion_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRIVE,
        SPIN,
        SETTLE
    } state_t;

    localparam logic CMD_DRIVE  = 1'b0;
    localparam logic CMD_SPIN   = 1'b1;
    localparam int   SPIN_BLANK = 2;

    // Duration travels beside this header so its width can follow DUR_W.
    typedef struct packed {
        logic       typ;
        logic       dir;
        logic [2:0] speed;
        logic [7:0] angle;
    } cmd_hdr_t;

    localparam int HDR_W = $bits(cmd_hdr_t);

endpackage

// File: rtl/motion_cmd_fifo.sv
// motion_cmd_fifo: synchronous power-of-two FIFO with count, full and empty.
module motion_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push,
    input  logic                 pop,
    input  logic [W-1:0]         din,
    output logic [W-1:0]         dout,
    output logic                 full,
    output logic                 empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr;
    logic [AW-1:0] rd;
    logic          do_push;
    logic          do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wr <= wr + AW'(1);
            if (do_pop)
                rd <= rd + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/motion_sequencer.sv
// motion_sequencer: queues drive/spin commands and plays them into motion_control.
// Optional bumper abort (bump/abort ports) is built with MOTION_SEQ_BUMP_EN.
module motion_sequencer
    import motion_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int DUR_W         = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int SPIN_TIMEOUT  = 65535
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MOTION_SEQ_BUMP_EN
    input  logic             bump,
    output logic             abort,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_type,
    input  logic             cmd_dir,
    input  logic [2:0]       cmd_speed,
    input  logic [7:0]       cmd_angle,
    input  logic [DUR_W-1:0] cmd_duration,
    input  logic             done_spin,
    output logic             mc_command_type,
    output logic [2:0]       mc_input_speed,
    output logic [7:0]       mc_angle,
    output logic             mc_direction,
    output logic             tick_clr,
    output logic             busy,
    output logic             cmd_done,
    output logic             spin_err
);

    localparam int          CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int          SW  = $clog2(SETTLE_CYCLES + 1);
    localparam int          FW  = HDR_W + DUR_W;
    localparam logic [15:0] TMO = 16'(SPIN_TIMEOUT);

    state_t           state;
    state_t           nstate;
    cmd_hdr_t         head;
    cmd_hdr_t         mc_q;
    cmd_hdr_t         mc_n;
    logic [FW-1:0]    head_raw;
    logic [DUR_W-1:0] head_dur;
    logic [DUR_W-1:0] dur_cnt;
    logic [15:0]      spin_cnt;
    logic [SW-1:0]    st_cnt;
    logic [SW-1:0]    st_cnt_n;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_n;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             flush;
    logic             bumped;
    logic             spin_ok;
    logic             spin_tmo;
    logic             aborted;
    logic             aborted_n;
    logic             tick_n;
    logic             done_n;
    logic             busy_n;
    logic             err_n;

`ifdef MOTION_SEQ_BUMP_EN
    assign bumped    = bump && (state == DRIVE || state == SPIN);
    assign cmd_ready = !full && !bump;
`else
    assign bumped    = 1'b0;
    assign cmd_ready = !full;
`endif

    assign push    = cmd_valid && cmd_ready;
    assign pop     = state == LOAD;
    assign flush   = bumped;
    assign count_n = flush ? '0 : count + CW'(push) - CW'(pop);

    motion_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   ({cmd_type, cmd_dir, cmd_speed, cmd_angle, cmd_duration}),
        .dout  (head_raw),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign {head, head_dur} = head_raw;

    // done_spin is blanked while motion_control's registers catch up.
    assign spin_ok  = done_spin && spin_cnt > 16'(SPIN_BLANK);
    assign spin_tmo = spin_cnt >= TMO;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (!empty) nstate = LOAD;
            LOAD:    nstate = (head.typ == CMD_DRIVE) ? DRIVE : SPIN;
            DRIVE:   if (bumped || dur_cnt <= DUR_W'(1)) nstate = SETTLE;
            SPIN:    if (bumped || spin_ok || spin_tmo) nstate = SETTLE;
            SETTLE:  if (st_cnt == SW'(1)) nstate = empty ? IDLE : LOAD;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        mc_n      = '0;
        st_cnt_n  = st_cnt;
        aborted_n = aborted;
        if (pop)
            aborted_n = 1'b0;
        if (bumped)
            aborted_n = 1'b1;
        if (nstate == DRIVE || nstate == SPIN)
            mc_n = pop ? head : mc_q;
        if (nstate == SETTLE)
            st_cnt_n = (state == SETTLE) ? st_cnt - SW'(1) : SW'(SETTLE_CYCLES);
        tick_n = nstate == LOAD && head.typ == CMD_SPIN;
        done_n = nstate == SETTLE && st_cnt_n == SW'(1) && !aborted_n;
        busy_n = nstate != IDLE || count_n != '0;
        err_n  = spin_err || (state == SPIN && !bumped && !spin_ok && spin_tmo);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_q     <= '0;
            st_cnt   <= '0;
            aborted  <= 1'b0;
            tick_clr <= 1'b0;
            cmd_done <= 1'b0;
            busy     <= 1'b0;
            spin_err <= 1'b0;
        end else begin
            mc_q     <= mc_n;
            st_cnt   <= st_cnt_n;
            aborted  <= aborted_n;
            tick_clr <= tick_n;
            cmd_done <= done_n;
            busy     <= busy_n;
            spin_err <= err_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dur_cnt  <= '0;
            spin_cnt <= '0;
        end else if (state == LOAD) begin
            dur_cnt  <= (head_dur == '0) ? DUR_W'(1) : head_dur;
            spin_cnt <= 16'd1;
        end else begin
            if (state == DRIVE)
                dur_cnt <= dur_cnt - DUR_W'(1);
            if (state == SPIN && spin_cnt != 16'hFFFF)
                spin_cnt <= spin_cnt + 16'd1;
        end
    end

`ifdef MOTION_SEQ_BUMP_EN
    always_ff @(posedge clk) begin
        if (rst)
            abort <= 1'b0;
        else
            abort <= bumped;
    end
`endif

    assign mc_command_type = mc_q.typ;
    assign mc_direction    = mc_q.dir;
    assign mc_input_speed  = mc_q.speed;
    assign mc_angle        = mc_q.angle;

endmodule

// File: tb/tb_motion_sequencer.sv
// tb_motion_sequencer: randomized scoreboard bench for motion_sequencer.
// Expected command segments come from a behavioural model of the command rules.
module tb_motion_sequencer;

    localparam int DEPTH  = 4;
    localparam int DW     = 16;
    localparam int SETTLE = 4;
    localparam int TMO    = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_type;
    logic          cmd_dir;
    logic [2:0]    cmd_speed;
    logic [7:0]    cmd_angle;
    logic [DW-1:0] cmd_duration;
    logic          done_spin;
    logic          mc_command_type;
    logic [2:0]    mc_input_speed;
    logic [7:0]    mc_angle;
    logic          mc_direction;
    logic          tick_clr;
    logic          busy;
    logic          cmd_done;
    logic          spin_err;
`ifdef MOTION_SEQ_BUMP_EN
    logic          bump = 1'b0;
    logic          abort;
`endif

    always #5 clk = ~clk;

    motion_sequencer #(
        .FIFO_DEPTH    (DEPTH),
        .DUR_W         (DW),
        .SETTLE_CYCLES (SETTLE),
        .SPIN_TIMEOUT  (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
`ifdef MOTION_SEQ_BUMP_EN
        .bump            (bump),
        .abort           (abort),
`endif
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_type        (cmd_type),
        .cmd_dir         (cmd_dir),
        .cmd_speed       (cmd_speed),
        .cmd_angle       (cmd_angle),
        .cmd_duration    (cmd_duration),
        .done_spin       (done_spin),
        .mc_command_type (mc_command_type),
        .mc_input_speed  (mc_input_speed),
        .mc_angle        (mc_angle),
        .mc_direction    (mc_direction),
        .tick_clr        (tick_clr),
        .busy            (busy),
        .cmd_done        (cmd_done),
        .spin_err        (spin_err)
    );

    typedef struct {
        logic [12:0] hdr;
        int          len;
        bit          err;
        bit          spin;
    } exp_t;

    exp_t exp_q[$];
    int   e_q[$];
    int   d_q[$];
    int   checks   = 0;
    int   passes   = 0;
    bit   mon_hold = 1'b1;
    bit   exp_err  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Model: a drive lasts max(dur,1); a spin ends at the first done after
    // the blank window, or at the timeout with a sticky error.
    task automatic issue(input bit typ, input bit dir, input logic [2:0] spd,
                         input logic [7:0] ang, input int dur, input int e,
                         input int d, input int maxwait, output bit ok);
        exp_t x;
        int   n = 0;
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_type     = typ;
        cmd_dir      = dir;
        cmd_speed    = spd;
        cmd_angle    = ang;
        cmd_duration = DW'(dur);
        while (!cmd_ready && n < maxwait) begin
            @(negedge clk);
            n++;
        end
        ok = cmd_ready;
        if (ok) begin
            x.hdr  = {typ, dir, spd, ang};
            x.spin = typ;
            if (!typ) begin
                x.len = (dur == 0) ? 1 : dur;
            end else begin
                x.len = (d >= 3 && d <= TMO) ? d : TMO;
                if (!(d >= 3 && d <= TMO))
                    exp_err = 1'b1;
                e_q.push_back(e);
                d_q.push_back(d);
            end
            x.err = exp_err;
            exp_q.push_back(x);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    task automatic wait_active(input string nm);
        int n = 0;
        while (mc_input_speed == 3'd0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, mc_input_speed != 3'd0, 1);
    endtask

    // Plays done_spin against each spin's schedule, counted from SPIN cycle 1.
    initial begin : spin_drv
        int n  = 0;
        int e  = 0;
        int d  = 0;
        bit in = 1'b0;
        done_spin = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_hold) begin
                in = 1'b0;
                done_spin = 1'b0;
            end else if (mc_command_type && mc_input_speed != 3'd0) begin
                if (!in) begin
                    in = 1'b1;
                    n  = 0;
                    e  = (e_q.size() != 0) ? e_q.pop_front() : 0;
                    d  = (d_q.size() != 0) ? d_q.pop_front() : 0;
                end
                n++;
                done_spin = (n == e) || (n == d);
            end else begin
                in = 1'b0;
                done_spin = 1'b0;
            end
        end
    end

    initial begin : monitor
        bit          in        = 1'b0;
        bit          tick_prev = 1'b0;
        bit          tick_seg  = 1'b0;
        bit          hchg      = 1'b0;
        logic [12:0] hdr       = '0;
        logic [12:0] cur;
        int          len       = 0;
        int          since     = 0;
        exp_t        x;
        forever begin
            @(negedge clk);
            if (mon_hold) begin
                in        = 1'b0;
                since     = 0;
                tick_prev = 1'b0;
            end else begin
                cur = {mc_command_type, mc_direction, mc_input_speed, mc_angle};
                if (mc_input_speed != 3'd0) begin
                    if (!in) begin
                        in       = 1'b1;
                        len      = 0;
                        hdr      = cur;
                        tick_seg = tick_prev;
                        hchg     = 1'b0;
                    end else if (cur !== hdr) begin
                        hchg = 1'b1;
                    end
                    len++;
                end else if (in) begin
                    in    = 1'b0;
                    since = 1;
                    chk("expect_avail", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        x = exp_q.pop_front();
                        chk("seg_fields", hdr, x.hdr);
                        chk("seg_len", len, x.len);
                        chk("seg_stable", hchg, 0);
                        chk("tick_clr", tick_seg, x.spin);
                        chk("spin_err", spin_err, x.err);
                    end
                end
                if (since == SETTLE) begin
                    chk("cmd_done", cmd_done, 1);
                    since = 0;
                end else begin
                    if (cmd_done)
                        chk("stray_done", cmd_done, 0);
                    if (since != 0)
                        since++;
                end
`ifdef MOTION_SEQ_BUMP_EN
                if (abort)
                    chk("stray_abort", abort, 0);
`endif
                tick_prev = tick_clr;
            end
        end
    end

    initial begin : stim
        bit ok;
        int acc;
        bit quiet;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_type     = 1'b0;
        cmd_dir      = 1'b0;
        cmd_speed    = '0;
        cmd_angle    = '0;
        cmd_duration = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mc", {mc_command_type, mc_direction, mc_input_speed, mc_angle}, 0);
        chk("rst_flags", {tick_clr, cmd_done, spin_err}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        mon_hold = 1'b0;

        // First command into an idle, empty FIFO: active on the third cycle.
        issue(1'b0, 1'b0, 3'b011, 8'h00, 5, 0, 0, 0, ok);
        chk("lat_push", ok, 1);
        @(negedge clk);
        chk("lat_c1", mc_input_speed, 0);
        @(negedge clk);
        chk("lat_c2", mc_input_speed, 0);
        @(negedge clk);
        chk("lat_c3", mc_input_speed, 3);
        wait_idle();

        // Fill behind a long drive; the fifth offer must be refused.
        issue(1'b0, 1'b1, 3'b101, 8'h80, 40, 0, 0, 0, ok);
        wait_active("fill_active");
        acc = 0;
        issue(1'b1, 1'b1, 3'd2, 8'h00, 0, 1, 6, 0, ok);
        acc += int'(ok);
        issue(1'b1, 1'b0, 3'd6, 8'h10, 0, 2, 0, 0, ok);
        acc += int'(ok);
        issue(1'b0, 1'b0, 3'd1, 8'h33, 0, 0, 0, 0, ok);
        acc += int'(ok);
        issue(1'b0, 1'b1, 3'd7, 8'h95, 3, 0, 0, 0, ok);
        acc += int'(ok);
        chk("fill_accepted", acc, 4);
        issue(1'b0, 1'b0, 3'd4, 8'h01, 2, 0, 0, 0, ok);
        chk("full_ready", ok, 0);
        wait_idle();

        for (int i = 0; i < 30; i++) begin
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(1, 7)), 8'($urandom),
                  int'($urandom_range(0, 10)), int'($urandom_range(0, 2)),
                  int'($urandom_range(3, 24)), 400, ok);
            if (!ok)
                chk("rand_push", ok, 1);
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        wait_idle();

        // Reset in the middle of a drive with two commands queued.
        issue(1'b0, 1'b0, 3'd4, 8'h22, 30, 0, 0, 0, ok);
        issue(1'b0, 1'b1, 3'd3, 8'h44, 4, 0, 0, 0, ok);
        issue(1'b0, 1'b0, 3'd5, 8'h66, 4, 0, 0, 0, ok);
        wait_active("rst_active");
        @(posedge clk);
        #1 mon_hold = 1'b1;
        rst = 1'b1;
        exp_q.delete();
        e_q.delete();
        d_q.delete();
        exp_err = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_mc", {mc_command_type, mc_direction, mc_input_speed, mc_angle}, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_flags", {tick_clr, cmd_done, spin_err}, 0);
        quiet = 1'b0;
        repeat (12) begin
            @(negedge clk);
            quiet |= busy | cmd_done | (mc_input_speed != 3'd0);
        end
        chk("post_rst_quiet", quiet, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
